// File: rtl/alu_src_sel_pipe.sv
// Registered ALU operand-source selector with a two-entry skid buffer (output + skid register).
// Optional forwarding override compiled in with ALU_SRC_FWD_EN.
module alu_src_sel_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 4,
    parameter int unsigned SELW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       src_sel,
    input  logic [NSRC*WIDTH-1:0] src_bus,
    input  logic                  fwd_en,
    input  logic [WIDTH-1:0]      fwd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_operand,
    output logic [SELW-1:0]       out_src,
    output logic                  sel_err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  sk_data;
    logic [SELW-1:0]   sk_src;
    logic [WIDTH-1:0]  cap_data;
    logic [SELW-1:0]   cap_src;
    logic              cap_err;
    logic              acc;
    logic              pop;
    logic              or_ld_in;
    logic              or_ld_sk;
    logic              sk_ld;

    // Operand capture: loop-based select keeps the slice index in range for any src_sel.
    always_comb begin
        cap_data = '0;
        cap_src  = src_sel;
        cap_err  = 1'b1;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (src_sel == SELW'(k)) begin
                cap_data = src_bus[k*WIDTH +: WIDTH];
                cap_err  = 1'b0;
            end
        end
`ifdef ALU_SRC_FWD_EN
        if (fwd_en) begin
            cap_data = fwd_data;
            cap_src  = '1;
            cap_err  = 1'b0;
        end
`endif
    end

`ifndef ALU_SRC_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{fwd_en, fwd_data};
`endif

    // Next-state and register-load decode; flush discards any same-cycle accept.
    always_comb begin
        state_nxt = state;
        or_ld_in  = 1'b0;
        or_ld_sk  = 1'b0;
        sk_ld     = 1'b0;
        acc       = in_valid && in_ready;
        pop       = out_valid && out_ready;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        state_nxt = ST_ONE;
                        or_ld_in  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (acc && !pop) begin
                        state_nxt = ST_TWO;
                        sk_ld     = 1'b1;
                    end else if (acc && pop) begin
                        or_ld_in  = 1'b1;
                    end else if (pop) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_nxt = ST_ONE;
                        or_ld_sk  = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // State, handshake flags and data registers; handshake flags follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_EMPTY;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            out_operand <= '0;
            out_src     <= '0;
            sk_data     <= '0;
            sk_src      <= '0;
            sel_err     <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != ST_EMPTY);
            in_ready  <= (state_nxt != ST_TWO);
            if (or_ld_in) begin
                out_operand <= cap_data;
                out_src     <= cap_src;
            end else if (or_ld_sk) begin
                out_operand <= sk_data;
                out_src     <= sk_src;
            end
            if (sk_ld) begin
                sk_data <= cap_data;
                sk_src  <= cap_src;
            end
            if (acc && !flush && cap_err) begin
                sel_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_src_sel_pipe.md
# alu_src_sel_pipe

Parametrised, registered ALU operand-source selector with a two-entry skid buffer, one per ALU input port. It replaces the combinational 2:1 source mux in front of the ALU. It selects one of NSRC operand sources, with an optional forwarding override, and delivers the operand through a valid/ready pipeline stage. Back-pressure from the execute stage is then absorbed without a combinational ready path.

## Interface
- WIDTH, 32, operand width in bits
- NSRC, 4, number of operand sources (2..16)
- SELW, 2, select width; NSRC ≤ 2^SELW required
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous discard of all buffered operands
- in_valid  in  1  upstream operand request valid
- in_ready  out  1  stage can accept a request
- src_sel  in  SELW  source index
- src_bus  in  NSRC*WIDTH  sources packed; source k is bits [k*WIDTH +: WIDTH]
- fwd_en  in  1  forwarding override request
- fwd_data  in  WIDTH  forwarded operand
- out_valid  out  1  operand valid to ALU
- out_ready  in  1  ALU accepts operand
- out_operand  out  WIDTH  selected operand, registered
- out_src  out  SELW  index that produced out_operand; all-ones when forwarded
- sel_err  out  1  sticky: an accepted src_sel was ≥ NSRC

## Operation
- Accept when in_valid && in_ready.
- Captured value:
  - fwd_data when forwarding is active, i.e. fwd_en=1 and the macro is compiled in.
  - Otherwise src_bus slice src_sel.
  - Otherwise zero when src_sel ≥ NSRC; sel_err is then set.
- Output register (OR) plus skid register (SK). The state machine has three states:
  - EMPTY: OR empty, SK empty.
  - ONE: OR full.
  - TWO: OR full and SK full.
- in_ready = !SK_full. It is a registered condition and does not depend combinationally on out_ready.
- Transitions (acc = accept, pop = out_valid && out_ready):
  - EMPTY: acc → ONE, with data to OR.
  - ONE: acc && !pop → TWO, with data to SK. acc && pop → ONE, with data to OR. pop only → EMPTY.
  - TWO: pop → ONE, with SK moved to OR. No accept is possible in TWO.
- Ordering is strictly FIFO. No operand is dropped or duplicated except on flush or reset.
- flush: the next state is EMPTY and any accept in the same cycle is discarded. sel_err is not cleared by flush.
- out_operand and out_src hold their value while out_valid=1 && out_ready=0.
- The SELW width is computed from NSRC. The source slice index is never out of range, because of the ≥ NSRC guard.

## Timing
- Latency: accept in cycle N → out_valid in cycle N+1.
- Throughput: one operand per cycle while out_ready=1.
- Reset values (rst sampled high at an edge):
  - out_valid=0, out_operand=0, out_src=0, sel_err=0.
  - in_ready=1 from the first cycle after reset.
- rst has priority over flush. Both have priority over accept and pop.
- Reset or flush mid-transfer: the pending pop is not considered completed. Downstream must ignore out_valid in that cycle's handshake.
- src_sel, src_bus, fwd_en and fwd_data are sampled only on the accept edge.

## Configuration
- ALU_SRC_FWD_EN defined: forwarding override is active; a forwarded operand reports out_src = all-ones.
- Not defined:
  - fwd_en and fwd_data remain ports but are ignored.
  - Selection is from src_bus only.
  - out_src never reports all-ones unless src_sel was itself all-ones.

## Test plan
- Reset:
  - Stimulus: rst=1 for 2 cycles with in_valid=1, then release.
  - Response: out_valid=0 and sel_err=0 during reset; in_ready=1 after; no operand emitted.
- Streaming:
  - Stimulus: NSRC=4, WIDTH=32, src_bus = {0x4444_4444, 0x3333_3333, 0x2222_2222, 0x1111_1111}, src_sel = 0,1,2,3 on consecutive cycles, out_ready=1.
  - Response: out_operand = 0x1111_1111, 0x2222_2222, 0x3333_3333, 0x4444_4444 on cycles 1..4; out_src = 0..3.
- Back-pressure:
  - Stimulus: out_ready=0 while sending src_sel = 1 then 2.
  - Response: in_ready falls to 0 after the second accept; out_operand holds 0x2222_2222.
  - Stimulus: raise out_ready.
  - Response: 0x2222_2222 then 0x3333_3333 are delivered in order, and in_ready=1 again.
- Forwarding (macro defined):
  - Stimulus: fwd_en=1, fwd_data=0xDEAD_BEEF, src_sel=0.
  - Response: out_operand=0xDEAD_BEEF, out_src=3.
  - Same stimulus with the macro undefined: out_operand=0x1111_1111, out_src=0.
- Out-of-range select:
  - Stimulus: NSRC=3, SELW=2, src_sel=3.
  - Response: out_operand=0, sel_err=1 and held across flush; cleared only by rst.
- Flush:
  - Stimulus: fill to state TWO with out_ready=0, then assert flush together with in_valid=1.
  - Response: next cycle out_valid=0 and in_ready=1; the flushed and concurrent operands never appear.
